// File: rtl/one_counter_ctrl.sv
// Control FSM for the one-counter datapath: loads DataIn, counts its set bits by
// shift-and-test through the register file, then latches the count into Out.
module one_counter_ctrl #(
    parameter logic [3:0] R_DATA   = 4'd0,
    parameter logic [3:0] R_CNT    = 4'd1,
    parameter logic [2:0] ALU_PASS = 3'b000,
    parameter logic [2:0] ALU_INC  = 3'b001,
    parameter logic [2:0] ALU_SHR  = 3'b010,
    parameter logic [2:0] ALU_CLR  = 3'b011
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Start,
    input  logic [15:0] Datapath,
    output logic        IE,
    output logic [3:0]  WAA,
    output logic [3:0]  WAB,
    output logic [3:0]  RAA,
    output logic [3:0]  RAB,
    output logic        WEA,
    output logic        WEB,
    output logic        REA,
    output logic        REB,
    output logic [2:0]  S_ALU,
    output logic        shift_ctrl,
    output logic        OE,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLR,
        TEST,
        INC,
        SHIFT,
        OUT,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Moore decode: every output depends on state alone; only TEST and IDLE look at inputs,
    // and only to pick the next state.
    always_comb begin
        next_state = state;
        IE         = 1'b0;
        WAA        = 4'd0;
        WAB        = 4'd0;
        RAA        = 4'd0;
        RAB        = 4'd0;
        WEA        = 1'b0;
        WEB        = 1'b0;
        REA        = 1'b0;
        REB        = 1'b0;
        S_ALU      = ALU_PASS;
        shift_ctrl = 1'b0;
        OE         = 1'b0;
        Busy       = 1'b1;
        Done       = 1'b0;

        case (state)
            IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                IE         = 1'b1;
                WEB        = 1'b1;
                WAB        = R_DATA;
                next_state = CLR;
            end
            CLR: begin
                REA        = 1'b1;
                RAA        = R_CNT;
                S_ALU      = ALU_CLR;
                WEA        = 1'b1;
                WAA        = R_CNT;
                next_state = TEST;
            end
            TEST: begin
                REB = 1'b1;
                RAB = R_DATA;
                if (Datapath == 16'h0000) begin
                    next_state = OUT;
                end else if (Datapath[0]) begin
                    next_state = INC;
                end else begin
                    next_state = SHIFT;
                end
            end
            INC: begin
                REA        = 1'b1;
                RAA        = R_CNT;
                S_ALU      = ALU_INC;
                WEA        = 1'b1;
                WAA        = R_CNT;
                next_state = SHIFT;
            end
            SHIFT: begin
                REB        = 1'b1;
                RAB        = R_DATA;
                S_ALU      = ALU_SHR;
                WEB        = 1'b1;
                WAB        = R_DATA;
                shift_ctrl = 1'b1;
                next_state = TEST;
            end
            OUT: begin
                REA        = 1'b1;
                RAA        = R_CNT;
                S_ALU      = ALU_PASS;
                OE         = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                Done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                Busy       = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

endmodule
